// File: rtl/pointing_device_decoder_if.sv
// Byte-stream and decoded-output bundle for the pointing device decoder.
// master: byte source / consumer side; slave: the decoder.
interface pointing_device_decoder_if;
   logic       rts;
   logic [7:0] rx_data;
   logic       rx_strobe;
   logic [7:0] device_id;
   logic       id_valid;
   logic [1:0] buttons;
   logic [7:0] dx;
   logic [7:0] dy;
   logic [9:0] cursor_x;
   logic [9:0] cursor_y;
   logic       packet_valid;
   logic       frame_error;

   modport master (
      output rts, rx_data, rx_strobe,
      input  device_id, id_valid, buttons, dx, dy,
      input  cursor_x, cursor_y, packet_valid, frame_error
   );

   modport slave (
      input  rts, rx_data, rx_strobe,
      output device_id, id_valid, buttons, dx, dy,
      output cursor_x, cursor_y, packet_valid, frame_error
   );
endinterface

// File: rtl/pointing_device_decoder.sv
// CD-i maneuvering-device receiver: ID capture, 3-byte packet framing,
// delta decode and clamped cursor integration. Ports: clk, reset_n, bus (slave).
module pointing_device_decoder #(
   parameter int X_MAX   = 767,
   parameter int Y_MAX   = 559,
   parameter int TIMEOUT = 250000
) (
   input logic                      clk,
   input logic                      reset_n,
   pointing_device_decoder_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [9:0] XM = 10'(X_MAX);
   localparam logic [9:0] YM = 10'(Y_MAX);

   typedef enum logic [1:0] {WAIT_ID, BYTE0, BYTE1, BYTE2} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    b0_q, b0_d;
   logic [7:0]    b1_q, b1_d;
   logic [7:0]    device_id_q, device_id_d;
   logic          id_valid_q, id_valid_d;
   logic [1:0]    buttons_q, buttons_d;
   logic [7:0]    dx_q, dx_d;
   logic [7:0]    dy_q, dy_d;
   logic [9:0]    cx_q, cx_d;
   logic [9:0]    cy_q, cy_d;
   logic          pv_q, pv_d;
   logic          fe_q, fe_d;
   logic [1:0]    tag;

   // 12-bit signed add of the sign-extended delta, then clamp to [0, mx].
   function automatic logic [9:0] clamp(
      input logic [9:0] cur,
      input logic [7:0] d,
      input logic [9:0] mx
   );
      logic signed [11:0] s;
      s = $signed({2'b00, cur}) + $signed({{4{d[7]}}, d});
      if (s < 0)
         return 10'd0;
      else if (s > $signed({2'b00, mx}))
         return mx;
      else
         return s[9:0];
   endfunction

   assign tag = bus.rx_data[7:6];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      device_id_d = device_id_q;
      id_valid_d  = id_valid_q;
      buttons_d   = buttons_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      pv_d        = 1'b0;
      fe_d        = 1'b0;

      if (bus.rts) begin
         state_d    = WAIT_ID;
         id_valid_d = 1'b0;
         cnt_d      = '0;
      end else if (bus.rx_strobe) begin
         cnt_d = '0;
         case (state_q)
            WAIT_ID: begin
               device_id_d = bus.rx_data;
               id_valid_d  = 1'b1;
               state_d     = BYTE0;
            end
            BYTE0: begin
               if (tag == 2'b11) begin
                  b0_d    = bus.rx_data;
                  state_d = BYTE1;
               end else begin
                  fe_d = 1'b1;
               end
            end
            BYTE1: begin
               if (tag == 2'b10) begin
                  b1_d    = bus.rx_data;
                  state_d = BYTE2;
               end else if (tag == 2'b11) begin
                  // header byte mid-packet: restart with it as b0
                  fe_d    = 1'b1;
                  b0_d    = bus.rx_data;
                  state_d = BYTE1;
               end else begin
                  fe_d    = 1'b1;
                  state_d = BYTE0;
               end
            end
            default: begin
               if (tag == 2'b10) begin
                  buttons_d = b0_q[5:4];
                  dx_d      = {b0_q[1:0], b1_q[5:0]};
                  dy_d      = {b0_q[3:2], bus.rx_data[5:0]};
                  cx_d      = clamp(cx_q, dx_d, XM);
                  cy_d      = clamp(cy_q, dy_d, YM);
                  pv_d      = 1'b1;
                  state_d   = BYTE0;
               end else if (tag == 2'b11) begin
                  fe_d    = 1'b1;
                  b0_d    = bus.rx_data;
                  state_d = BYTE1;
               end else begin
                  fe_d    = 1'b1;
                  state_d = BYTE0;
               end
            end
         endcase
      end else if (state_q == BYTE1 || state_q == BYTE2) begin
         // inter-byte gap watchdog only while a packet is in flight
         if (cnt_q == CW'(TIMEOUT - 1)) begin
            fe_d    = 1'b1;
            state_d = BYTE0;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= WAIT_ID;
         cnt_q       <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         device_id_q <= '0;
         id_valid_q  <= 1'b0;
         buttons_q   <= '0;
         dx_q        <= '0;
         dy_q        <= '0;
         cx_q        <= '0;
         cy_q        <= '0;
         pv_q        <= 1'b0;
         fe_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         device_id_q <= device_id_d;
         id_valid_q  <= id_valid_d;
         buttons_q   <= buttons_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         pv_q        <= pv_d;
         fe_q        <= fe_d;
      end
   end

   assign bus.device_id    = device_id_q;
   assign bus.id_valid     = id_valid_q;
   assign bus.buttons      = buttons_q;
   assign bus.dx           = dx_q;
   assign bus.dy           = dy_q;
   assign bus.cursor_x     = cx_q;
   assign bus.cursor_y     = cy_q;
   assign bus.packet_valid = pv_q;
   assign bus.frame_error  = fe_q;
endmodule
